// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared function-select and functional-unit state encodings
package mycpu_pkg;
  typedef enum logic [3:0] {
    FMOVA, FINC, FADD, FSUB, FDEC, FAND, FOR, FXOR,
    FNOT, FMOVB, FSHR, FSHL, FSRA, FSLA, FMUL, FCLR
  } fs_t;
  typedef enum logic [1:0] {IDLE, MUL, DONE} fu_state_t;
endpackage

// File: rtl/seq_fu_if.sv
// seq_fu_if: request/result handshake bundle for seq_fu
interface seq_fu_if import mycpu_pkg::*; #(parameter int DW = 16);
  logic in_valid;
  logic in_ready;
  fs_t fs_in;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic out_valid;
  logic out_ready;
  logic [DW-1:0] f_out;
  logic z_out;
  logic n_out;
  logic c_out;
  logic v_out;
  modport slave (
    input in_valid, fs_in, a_in, b_in, out_ready,
    output in_ready, out_valid, f_out, z_out, n_out, c_out, v_out
  );
  modport master (
    output in_valid, fs_in, a_in, b_in, out_ready,
    input in_ready, out_valid, f_out, z_out, n_out, c_out, v_out
  );
endinterface

// File: rtl/seq_mul.sv
// seq_mul: iterative shift-add signed multiplier with saturation to DW bits
module seq_mul #(parameter int DW = 16) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          done,
  output logic [DW-1:0] product,
  output logic          sat
);
  localparam int CW = $clog2(DW) + 1;
  localparam logic [2*DW-1:0] POS_MAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic [2*DW-1:0] NEG_LIM = {{DW{1'b0}}, 1'b1, {(DW-1){1'b0}}};
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*DW-1:0] acc_q, acc_d;
  logic [DW-1:0] mcand_q, mcand_d;
  logic neg_q, neg_d, busy_q, busy_d;
  logic [DW-1:0] mag_a, mag_b;
  logic [DW:0] sum;
  assign mag_a = a[DW-1] ? -a : a;
  assign mag_b = b[DW-1] ? -b : b;
  // low half of acc holds the shrinking multiplier, high half the partial sum
  assign sum = {1'b0, acc_q[2*DW-1:DW]} + {1'b0, acc_q[0] ? mcand_q : '0};
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    neg_d = neg_q;
    busy_d = busy_q;
    if (start) begin
      cnt_d = CW'(DW);
      acc_d = {{DW{1'b0}}, mag_b};
      mcand_d = mag_a;
      neg_d = a[DW-1] ^ b[DW-1];
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = {sum, acc_q[DW-1:1]};
      cnt_d = cnt_q - 1'b1;
      busy_d = cnt_q != CW'(1);
    end
  end
  // result is taken from the final iteration's next value so it lands with the last step
  assign done = busy_q && cnt_q == CW'(1);
  assign sat = neg_q ? acc_d > NEG_LIM : acc_d > POS_MAX;
  assign product = neg_q ? (sat ? {1'b1, {(DW-1){1'b0}}} : -acc_d[DW-1:0])
                         : (sat ? {1'b0, {(DW-1){1'b1}}} : acc_d[DW-1:0]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      mcand_q <= '0;
      neg_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      neg_q <= neg_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: rtl/seq_fu.sv
// seq_fu: handshaked functional unit, single-cycle ALU ops plus iterative multiply
module seq_fu import mycpu_pkg::*; #(parameter int DW = 16) (
  input logic clk,
  input logic rst_n,
  seq_fu_if.slave bus
);
  fu_state_t state_q, state_d;
  logic live_q;
  logic [DW-1:0] f_q, f_d, alu_f, mul_p;
  logic z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic alu_c, alu_v, accept, mul_start, mul_done, mul_sat;
  logic [DW-1:0] a, b;
  assign a = bus.a_in;
  assign b = bus.b_in;
  // live_q keeps in_ready low until the first edge after reset release
  assign bus.in_ready = live_q && (state_q == IDLE || (state_q == DONE && bus.out_ready));
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.out_valid = state_q == DONE;
  assign bus.f_out = f_q;
  assign bus.z_out = z_q;
  assign bus.n_out = n_q;
  assign bus.c_out = c_q;
  assign bus.v_out = v_q;
  always_comb begin
    alu_f = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.fs_in)
      FMOVA: alu_f = a;
      FINC: begin
        {alu_c, alu_f} = {1'b0, a} + (DW+1)'(1);
        alu_v = !a[DW-1] && alu_f[DW-1];
      end
      FADD: begin
        {alu_c, alu_f} = {1'b0, a} + {1'b0, b};
        alu_v = a[DW-1] == b[DW-1] && alu_f[DW-1] != a[DW-1];
      end
      FSUB: begin
        {alu_c, alu_f} = {1'b0, a} - {1'b0, b};
        alu_v = a[DW-1] != b[DW-1] && alu_f[DW-1] != a[DW-1];
      end
      FDEC: begin
        {alu_c, alu_f} = {1'b0, a} - (DW+1)'(1);
        alu_v = a[DW-1] && !alu_f[DW-1];
      end
      FAND: alu_f = a & b;
      FOR: alu_f = a | b;
      FXOR: alu_f = a ^ b;
      FNOT: alu_f = ~a;
      FMOVB: alu_f = b;
      FSHR: begin
        alu_f = {1'b0, b[DW-1:1]};
        alu_c = b[0];
      end
      FSHL: begin
        alu_f = {b[DW-2:0], 1'b0};
        alu_c = b[DW-1];
      end
      FSRA: begin
        alu_f = {b[DW-1], b[DW-1:1]};
        alu_c = b[0];
      end
      FSLA: begin
        alu_f = {b[DW-2:0], 1'b0};
        alu_c = b[DW-1];
        alu_v = b[DW-1] ^ b[DW-2];
      end
      default: alu_f = '0;
    endcase
  end
  seq_mul #(.DW(DW)) u_mul (
    .clk(clk),
    .rst_n(rst_n),
    .start(mul_start),
    .a(a),
    .b(b),
    .done(mul_done),
    .product(mul_p),
    .sat(mul_sat)
  );
  // result registers are cleared whenever out_valid will be low
  always_comb begin
    state_d = state_q;
    f_d = f_q;
    c_d = c_q;
    v_d = v_q;
    mul_start = 1'b0;
    if (accept) begin
      mul_start = bus.fs_in == FMUL;
      state_d = mul_start ? MUL : DONE;
      f_d = mul_start ? '0 : alu_f;
      c_d = !mul_start && alu_c;
      v_d = !mul_start && alu_v;
    end else if (state_q == MUL && mul_done) begin
      state_d = DONE;
      f_d = mul_p;
      c_d = 1'b0;
      v_d = mul_sat;
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
      f_d = '0;
      c_d = 1'b0;
      v_d = 1'b0;
    end
    z_d = state_d == DONE && f_d == '0;
    n_d = f_d[DW-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      live_q <= 1'b0;
      f_q <= '0;
      z_q <= 1'b0;
      n_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q <= 1'b1;
      f_q <= f_d;
      z_q <= z_d;
      n_q <= n_d;
      c_q <= c_d;
      v_q <= v_d;
    end
  end
endmodule

// File: tb/tb_seq_fu.sv
// tb_seq_fu: directed self-checking bench for seq_fu at DW=16
module tb_seq_fu;
  import mycpu_pkg::*;
  typedef struct {
    fs_t fs;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] f;
    logic [3:0] znvc;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n;
  int n_vec = 0;
  int n_err = 0;
  int lat;
  logic seen;
  vec_t vt [17] = '{
    '{FSLA, 16'h0000, 16'h4000, 16'h8000, 4'b0101},
    '{FSRA, 16'h0000, 16'h8001, 16'hC000, 4'b0110},
    '{FSHL, 16'h0000, 16'h8001, 16'h0002, 4'b0010},
    '{FDEC, 16'h0000, 16'h0000, 16'hFFFF, 4'b0110},
    '{FDEC, 16'h8000, 16'h0000, 16'h7FFF, 4'b0001},
    '{FINC, 16'hFFFF, 16'h0000, 16'h0000, 4'b1010},
    '{FSUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001},
    '{FAND, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100},
    '{FOR,  16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000},
    '{FXOR, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000},
    '{FNOT, 16'h00FF, 16'h1234, 16'hFF00, 4'b0100},
    '{FMOVB, 16'hFFFF, 16'h1234, 16'h1234, 4'b0000},
    '{FMOVA, 16'h8765, 16'h0001, 16'h8765, 4'b0100},
    '{FCLR, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000},
    '{FMUL, 16'h8000, 16'hFFFF, 16'h7FFF, 4'b0001},
    '{FMUL, 16'h8000, 16'h0001, 16'h8000, 4'b0100},
    '{FMUL, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0000}
  };
  always #5 clk = ~clk;
  seq_fu_if #(.DW(16)) bus();
  seq_fu #(.DW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic res(input string tag, input logic [15:0] f, input logic [3:0] znvc);
    check({tag, " f"}, 32'(bus.f_out), 32'(f));
    check({tag, " znvc"}, 32'({bus.z_out, bus.n_out, bus.c_out, bus.v_out}), 32'(znvc));
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic drive(input fs_t fs, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = 1'b1;
    bus.fs_in = fs;
    bus.a_in = a;
    bus.b_in = b;
  endtask
  task automatic issue(input fs_t fs, input logic [15:0] a, input logic [15:0] b, output int l);
    drive(fs, a, b);
    tick;
    bus.in_valid = 1'b0;
    l = 1;
    while (!bus.out_valid && l < 40) begin
      tick;
      l++;
    end
  endtask
  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.fs_in = FMOVA;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.out_ready = 1'b0;
    tick;
    tick;
    check("rst in_ready", 32'(bus.in_ready), 0);
    check("rst out_valid", 32'(bus.out_valid), 0);
    res("rst", 16'h0000, 4'b0000);
    rst_n = 1'b1;
    tick;
    check("ready after rst", 32'(bus.in_ready), 1);
    issue(FADD, 16'h7FFF, 16'h0001, lat);
    check("add latency", 32'(lat), 1);
    res("add ovf", 16'h8000, 4'b0101);
    bus.out_ready = 1'b1;
    tick;
    check("add drain", 32'(bus.out_valid), 0);
    res("idle clear", 16'h0000, 4'b0000);
    bus.out_ready = 1'b0;
    drive(FMUL, 16'hFFFD, 16'h0005);
    tick;
    bus.in_valid = 1'b0;
    check("mul busy ready", 32'(bus.in_ready), 0);
    for (int i = 2; i <= 17; i++) begin
      if (i == 6) drive(FADD, 16'h0001, 16'h0001);
      if (i == 7) bus.in_valid = 1'b0;
      tick;
      if (i == 16) check("mul early valid", 32'(bus.out_valid), 0);
    end
    check("mul valid at 17", 32'(bus.out_valid), 1);
    res("mul neg", 16'hFFF1, 4'b0100);
    check("mul done ready", 32'(bus.in_ready), 0);
    tick;
    res("mul hold", 16'hFFF1, 4'b0100);
    bus.out_ready = 1'b1;
    tick;
    check("mul drain", 32'(bus.out_valid), 0);
    issue(FMUL, 16'h0100, 16'h0200, lat);
    check("mul sat latency", 32'(lat), 17);
    res("mul sat", 16'h7FFF, 4'b0001);
    tick;
    check("mul sat drain", 32'(bus.out_valid), 0);
    drive(FSHR, 16'h0000, 16'h0003);
    tick;
    check("shr valid", 32'(bus.out_valid), 1);
    res("shr", 16'h0001, 4'b0010);
    drive(FSUB, 16'h0000, 16'h0001);
    tick;
    check("sub valid", 32'(bus.out_valid), 1);
    res("sub b2b", 16'hFFFF, 4'b0110);
    bus.in_valid = 1'b0;
    tick;
    check("b2b drain", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
    drive(FADD, 16'h0002, 16'h0003);
    tick;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      res("hold", 16'h0005, 4'b0000);
      check("hold ready", 32'(bus.in_ready), 0);
      check("hold valid", 32'(bus.out_valid), 1);
      tick;
    end
    bus.out_ready = 1'b1;
    tick;
    check("hold release", 32'(bus.out_valid), 0);
    foreach (vt[i]) begin
      issue(vt[i].fs, vt[i].a, vt[i].b, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), vt[i].fs == FMUL ? 17 : 1);
      res($sformatf("vec%0d", i), vt[i].f, vt[i].znvc);
    end
    tick;
    drive(FMUL, 16'h0007, 16'h0003);
    tick;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    rst_n = 1'b0;
    tick;
    check("midrst ready", 32'(bus.in_ready), 0);
    check("midrst valid", 32'(bus.out_valid), 0);
    res("midrst", 16'h0000, 4'b0000);
    tick;
    rst_n = 1'b1;
    tick;
    check("midrst release ready", 32'(bus.in_ready), 1);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      seen |= bus.out_valid;
      tick;
    end
    check("no stale result", 32'(seen), 0);
    issue(FMUL, 16'h0007, 16'h0003, lat);
    check("post rst mul latency", 32'(lat), 17);
    res("post rst mul", 16'h0015, 4'b0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
